// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812/SK6812 chain driver: default timing,
// FSM state type and the nanosecond-to-cycle conversion.
package ws2812_pkg;

    localparam int DEF_CLK_HZ       = 48000000;
    localparam int DEF_NUM_LEDS     = 8;
    localparam int DEF_BITS_PER_LED = 24;
    localparam int DEF_T0H_NS       = 350;
    localparam int DEF_T1H_NS       = 700;
    localparam int DEF_TBIT_NS      = 1250;
    localparam int DEF_TLATCH_US    = 80;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } state_t;

    // Nanoseconds to clock cycles, rounded up so no phase ever runs short.
    function automatic int cyc(input longint clk_hz, input longint ns);
        return int'((clk_hz / 64'sd1000000 * ns + 64'sd999) / 64'sd1000);
    endfunction

endpackage

// File: rtl/ws2812_bit_gen.sv
// Single-bit waveform generator: a start pulse begins one TBIT period whose
// high part lasts T1H or T0H cycles depending on the bit value.
module ws2812_bit_gen #(
    parameter int T0H  = 17,
    parameter int T1H  = 34,
    parameter int TBIT = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_val,
    output logic dout,
    output logic hi_end,
    output logic bit_end
);

    localparam int CW = $clog2(TBIT);
    localparam logic [CW-1:0] T0H_M1  = CW'(T0H - 1);
    localparam logic [CW-1:0] T1H_M1  = CW'(T1H - 1);
    localparam logic [CW-1:0] TBIT_M1 = CW'(TBIT - 1);

    logic          active;
    logic [CW-1:0] cnt;
    logic [CW-1:0] hi_last;

    assign hi_end  = active && (cnt == hi_last);
    assign bit_end = active && (cnt == TBIT_M1);

    // A start on the final cycle of a bit chains straight into the next bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            hi_last <= '0;
            dout    <= 1'b0;
        end else if (start) begin
            active  <= 1'b1;
            cnt     <= '0;
            hi_last <= bit_val ? T1H_M1 : T0H_M1;
            dout    <= 1'b1;
        end else if (bit_end) begin
            active  <= 1'b0;
            cnt     <= '0;
            dout    <= 1'b0;
        end else if (active) begin
            cnt     <= cnt + 1'b1;
            dout    <= (cnt < hi_last);
        end
    end

endmodule

// File: rtl/ws2812_chain.sv
// WS2812/SK6812 chain driver: takes a ready/valid pixel stream, sends NUM_LEDS
// pixels MSB first per frame and closes each frame with a latch gap.
module ws2812_chain
    import ws2812_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int NUM_LEDS     = DEF_NUM_LEDS,
    parameter int BITS_PER_LED = DEF_BITS_PER_LED,
    parameter int T0H_NS       = DEF_T0H_NS,
    parameter int T1H_NS       = DEF_T1H_NS,
    parameter int TBIT_NS      = DEF_TBIT_NS,
    parameter int TLATCH_US    = DEF_TLATCH_US
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BITS_PER_LED-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    underrun,
    output logic                    dout
);

    localparam int W      = BITS_PER_LED;
    localparam int T0H    = cyc(CLK_HZ, T0H_NS);
    localparam int T1H    = cyc(CLK_HZ, T1H_NS);
    localparam int TBIT   = cyc(CLK_HZ, TBIT_NS);
    localparam int TLATCH = cyc(CLK_HZ, 1000 * TLATCH_US);
    localparam int BW     = $clog2(W);
    localparam int PW     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int LW     = $clog2(TLATCH);

    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(NUM_LEDS - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(TLATCH - 1);

    if (!(T0H > 0 && T0H < T1H && T1H < TBIT)) begin : g_bad_timing
        $error("ws2812_chain: bit timing must satisfy 0 < T0H < T1H < TBIT cycles");
    end

    state_t        state;
    logic          hold_full;
    logic [W-1:0]  hold_data;
    logic [W-2:0]  rest;
    logic [BW-1:0] bit_cnt;
    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] lat_cnt;
    logic          frame_ok;

    logic handshake, last_bit, last_pix, load_new, next_bit;
    logic start, bit_val, hi_end, bit_end;

    assign in_ready  = !hold_full;
    assign busy      = (state != ST_IDLE);
    assign handshake = in_valid && !hold_full;
    assign last_bit  = (bit_cnt == BIT_LAST);
    assign last_pix  = (pix_cnt == PIX_LAST);

    // The MSB goes straight to the bit generator at load; rest holds the bits still to send.
    assign load_new = (state == ST_IDLE && hold_full) ||
                      (state == ST_LOW && bit_end && last_bit && !last_pix && hold_full);
    assign next_bit = (state == ST_LOW) && bit_end && !last_bit;
    assign start    = load_new || next_bit;
    assign bit_val  = load_new ? hold_data[W-1] : rest[W-2];

    ws2812_bit_gen #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_gen (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bit_val (bit_val),
        .dout    (dout),
        .hi_end  (hi_end),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            hold_full  <= 1'b0;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            lat_cnt    <= '0;
            frame_ok   <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;

            if (handshake)
                hold_full <= 1'b1;
            else if (load_new)
                hold_full <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (hold_full) begin
                        state   <= ST_HIGH;
                        pix_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_HIGH: begin
                    if (hi_end)
                        state <= ST_LOW;
                end
                ST_LOW: begin
                    if (bit_end) begin
                        if (!last_bit) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= ST_HIGH;
                        end else if (last_pix) begin
                            state    <= ST_LATCH;
                            lat_cnt  <= '0;
                            frame_ok <= 1'b1;
                        end else if (hold_full) begin
                            pix_cnt <= pix_cnt + 1'b1;
                            bit_cnt <= '0;
                            state   <= ST_HIGH;
                        end else begin
                            underrun <= 1'b1;
                            state    <= ST_LATCH;
                            lat_cnt  <= '0;
                            frame_ok <= 1'b0;
                        end
                    end
                end
                ST_LATCH: begin
                    if (lat_cnt == LAT_LAST) begin
                        state      <= ST_IDLE;
                        frame_done <= frame_ok;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pixel data carries no reset; hold_full alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (handshake)
            hold_data <= in_data;
        if (load_new)
            rest <= hold_data[W-2:0];
        else if (next_bit)
            rest <= {rest[W-3:0], 1'b0};
    end

endmodule

// File: tb/tb_ws2812_chain.sv
// Scoreboard bench for ws2812_chain: expected bits, frame_done and underrun
// events are queued as pixels are issued and matched against decoded dout.
module tb_ws2812_chain;

    localparam int T0H_C   = 17;
    localparam int T1H_C   = 34;
    localparam int TBIT_C  = 60;
    localparam int TL_C    = 3840;
    localparam int GAP_B2B = TBIT_C + TL_C + 1;
    localparam int K_BIT   = 0;
    localparam int K_FD    = 1;
    localparam int K_UR    = 2;

    typedef struct {
        int ch;
        int kind;
        int val;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] in_data0 = '0;
    logic        in_valid0 = 1'b0;
    logic        in_ready0, busy0, fd0, ur0, dout0;
    logic [31:0] in_data1 = '0;
    logic        in_valid1 = 1'b0;
    logic        in_ready1, busy1, fd1, ur1, dout1;

    logic prev_d[2]    = '{1'b0, 1'b0};
    bit   have_bit[2]  = '{1'b0, 1'b0};
    int   last_rise[2] = '{0, 0};
    int   cur_val[2]   = '{0, 0};

    ws2812_chain #(.NUM_LEDS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data0),
        .in_valid   (in_valid0),
        .in_ready   (in_ready0),
        .busy       (busy0),
        .frame_done (fd0),
        .underrun   (ur0),
        .dout       (dout0)
    );

    ws2812_chain #(.NUM_LEDS(1), .BITS_PER_LED(32)) dut32 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data1),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .busy       (busy1),
        .frame_done (fd1),
        .underrun   (ur1),
        .dout       (dout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_ev(input int ch, input int kind, input int val, input int gap);
        exp_t e;
        e.ch = ch; e.kind = kind; e.val = val; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Reference model: a pixel is its bits MSB first, each a full bit period apart.
    task automatic push_pixel(input int ch, input int w, input logic [31:0] d,
                              input int first_gap, input bit fend);
        for (int b = w - 1; b >= 0; b--)
            push_ev(ch, K_BIT, int'(d[b]), (b == w - 1) ? first_gap : TBIT_C);
        if (fend)
            push_ev(ch, K_FD, 0, TBIT_C + TL_C);
    endtask

    task automatic take(input int ch, input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        e.ch = 0; e.kind = 0; e.val = 0; e.gap = 0;
        if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_event_ch%0d_kind%0d", ch, kind), 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk("event_channel", ch, e.ch);
        chk("event_kind", kind, e.kind);
        ok = (e.ch == ch) && (e.kind == kind);
    endtask

    task automatic mon_ch(input int ch);
        logic d, fd, ur, by;
        exp_t e;
        bit   ok;
        d  = (ch != 0) ? dout1 : dout0;
        fd = (ch != 0) ? fd1   : fd0;
        ur = (ch != 0) ? ur1   : ur0;
        by = (ch != 0) ? busy1 : busy0;
        if (!rst) begin
            prev_d[ch]   = 1'b0;
            have_bit[ch] = 1'b0;
            return;
        end
        if (d && !prev_d[ch]) begin
            take(ch, K_BIT, e, ok);
            have_bit[ch] = ok;
            if (ok) begin
                if (e.gap >= 0)
                    chk("bit_period", cyc - last_rise[ch], e.gap);
                cur_val[ch] = e.val;
            end
            last_rise[ch] = cyc;
        end
        if (!d && prev_d[ch] && have_bit[ch]) begin
            chk("high_time", cyc - last_rise[ch], (cur_val[ch] != 0) ? T1H_C : T0H_C);
            have_bit[ch] = 1'b0;
        end
        if (fd) begin
            take(ch, K_FD, e, ok);
            if (ok)
                chk("frame_done_time", cyc - last_rise[ch], e.gap);
            chk("busy_at_frame_done", int'(by), 0);
        end
        if (ur) begin
            take(ch, K_UR, e, ok);
            if (ok)
                chk("underrun_time", cyc - last_rise[ch], e.gap);
        end
        prev_d[ch] = d;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_ch(0);
            mon_ch(1);
        end
    end

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send(input int ch, input logic [31:0] d, input bit keep);
        int t = 0;
        if (ch == 0) begin in_data0 = d[23:0]; in_valid0 = 1'b1; end
        else         begin in_data1 = d;       in_valid1 = 1'b1; end
        while (!((ch != 0) ? in_ready1 : in_ready0) && t <= 9000) begin
            @(negedge clk);
            t++;
        end
        if (t > 9000) begin
            chk("ready_timeout", 0, 1);
        end else begin
            @(posedge clk);
            @(negedge clk);
            chk("ready_low_while_full", int'((ch != 0) ? in_ready1 : in_ready0), 0);
        end
        if (!keep || t > 9000) begin
            if (ch == 0) in_valid0 = 1'b0;
            else         in_valid1 = 1'b0;
        end
    endtask

    task automatic wait_frame(input int ch);
        int t = 0;
        while (!((ch != 0) ? busy1 : busy0) && t < 200) begin @(negedge clk); t++; end
        chk("busy_rise", int'((ch != 0) ? busy1 : busy0), 1);
        t = 0;
        while (((ch != 0) ? busy1 : busy0) && t < 30000) begin @(negedge clk); t++; end
        chk("busy_fall", int'((ch != 0) ? busy1 : busy0), 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_dout"}, int'(dout0), 0);
        chk({tag, "_in_ready"}, int'(in_ready0), 1);
        chk({tag, "_busy"}, int'(busy0), 0);
        chk({tag, "_frame_done"}, int'(fd0), 0);
        chk({tag, "_underrun"}, int'(ur0), 0);
        chk({tag, "_dout32"}, int'(dout1), 0);
        chk({tag, "_in_ready32"}, int'(in_ready1), 1);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: cycle budget exhausted, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d0, d1;
        logic [23:0] c;

        // Reset held from time zero, then released.
        #23;
        chk_idle("reset");
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("after_release");

        // Directed full frame.
        push_pixel(0, 24, 32'h00FF0000, -1, 1'b0);
        send(0, 32'h00FF0000, 1'b1);
        push_pixel(0, 24, 32'h0000000F, TBIT_C, 1'b1);
        send(0, 32'h0000000F, 1'b0);
        wait_frame(0);

        // Random full frames after random idle gaps.
        for (int f = 0; f < 2; f++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            d0 = $urandom & 32'h00FFFFFF;
            d1 = $urandom & 32'h00FFFFFF;
            push_pixel(0, 24, d0, -1, 1'b0);
            send(0, d0, 1'b1);
            push_pixel(0, 24, d1, TBIT_C, 1'b1);
            send(0, d1, 1'b0);
            wait_frame(0);
        end

        // Underrun: one pixel of a two-pixel frame.
        push_pixel(0, 24, 32'h00AAAAAA, -1, 1'b0);
        push_ev(0, K_UR, 0, TBIT_C);
        send(0, 32'h00AAAAAA, 1'b0);
        wait_frame(0);
        repeat (5) @(negedge clk);
        chk("idle_after_underrun", int'(busy0), 0);

        // Backpressure: valid held high with counter data across three frames.
        c = 24'($urandom);
        for (int k = 0; k < 6; k++) begin
            push_pixel(0, 24, {8'h00, c},
                       (k % 2 == 1) ? TBIT_C : ((k == 0) ? -1 : GAP_B2B), (k % 2) == 1);
            send(0, {8'h00, c}, k < 5);
            c = c + 24'd1;
        end
        wait_frame(0);

        // Reset during the high phase of the first bit.
        push_ev(0, K_BIT, 0, -1);
        send(0, 32'h005A5A5A, 1'b0);
        send(0, 32'h00C3C3C3, 1'b0);
        repeat (8) @(negedge clk);
        chk("dout_high_before_reset", int'(dout0), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk_idle("mid_bit_reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("mid_bit_release");
        repeat (300) @(negedge clk);
        chk("old_pixel_dropped_busy", int'(busy0), 0);

        // 32-bit single-LED chain, two frames back to back.
        d1 = $urandom;
        push_pixel(1, 32, 32'h80000001, -1, 1'b1);
        send(1, 32'h80000001, 1'b1);
        push_pixel(1, 32, d1, GAP_B2B, 1'b1);
        send(1, d1, 1'b0);
        wait_frame(1);
        wait_frame(1);

        repeat (10) @(negedge clk);
        chk("pending_expected_events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_chain.md
Name: ws2812_chain

Overview:
- Parametrised WS2812/SK6812 chain driver and successor to ledstring.
- Accepts a ready/valid pixel stream and serialises NUM_LEDS pixels per frame onto one data line.
- Per-bit timing is derived from CLK_HZ, so it is clock-independent.
- Closes each frame with a latch gap; mid-frame starvation is detected and reported.
- Sits between a pixel source (pattern generator or frame store) and the LED strip pin.

Parameters:
- CLK_HZ, 48000000: system clock frequency; must be a multiple of 1 MHz.
- NUM_LEDS, 8: pixels per frame, >=1.
- BITS_PER_LED, 24: 24 for RGB, 32 for RGBW; sent MSB first.
- T0H_NS, 350: high time of a '0' bit.
- T1H_NS, 700: high time of a '1' bit.
- TBIT_NS, 1250: total bit period.
- TLATCH_US, 80: low time that closes a frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  BITS_PER_LED  pixel word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  holding register empty; the word is accepted on valid&ready.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse at the end of a complete frame's latch.
- underrun  out  1  one-cycle pulse when a frame is aborted for lack of data.
- dout  out  1  strip data line, registered.

Behaviour:
- Cycle counts use CYC(ns) = (CLK_HZ/1e6*ns + 999)/1000, i.e. rounded up.
  - Defaults: T0H=17, T1H=34, TBIT=60, TLATCH=3840 cycles.
- Elaboration error unless 0 < T0H < T1H < TBIT.
- Reset values (on rst low, asynchronously):
  - dout=0, busy=0, frame_done=0, underrun=0.
  - Holding register empty, so in_ready=1.
  - State IDLE; bit counter and pixel counter at 0.
- One-word holding register:
  - in_ready = !hold_full.
  - A handshake sets hold_full on that edge.
  - hold_full clears on the edge where the shifter loads from it.
  - A simultaneous load and new handshake leaves hold_full at 1.
- FSM states: IDLE, HIGH, LOW, LATCH.
- IDLE:
  - If hold_full, load the shifter, set pix_cnt=0 and bit_cnt=0, and go to HIGH.
  - dout=1 from that edge.
  - Latency: handshake at edge E0 gives dout high from E1.
- HIGH:
  - dout=1 for exactly T1H cycles if the shifter MSB is 1, otherwise T0H cycles.
  - Then go to LOW.
- LOW:
  - dout=0 until the bit totals exactly TBIT cycles.
  - If it was not the last bit of the pixel: shift left, bit_cnt+1, go to HIGH.
  - If it was the last bit and pix_cnt == NUM_LEDS-1: go to LATCH.
  - If it was the last bit, pix_cnt < NUM_LEDS-1 and hold_full: load the shifter, pix_cnt+1, go to HIGH. There is no gap between pixels.
  - If it was the last bit, pix_cnt < NUM_LEDS-1 and the holding register is empty: pulse underrun and go to LATCH.
- LATCH:
  - dout=0 for TLATCH cycles, then go to IDLE.
  - frame_done pulses on the exit edge only if the frame completed; no pulse after an underrun.
  - in_ready still follows hold_full during LATCH, so the next frame's first pixel can be prefetched.
  - A prefetched pixel starts a frame the cycle after IDLE is entered.
- busy = (state != IDLE).
- Reset mid-operation drops dout immediately, discards the holding and shift registers, and emits no pulses.
- Back-to-back frames are separated by exactly TLATCH+1 low cycles.

Decomposition:
- Package ws2812_pkg holds:
  - the CYC() constant function;
  - the state enum;
  - default timing constants.
- Sub-module ws2812_bit_gen: loads a bit value on start, drives the high/low waveform, and pulses bit_end on the last cycle of the TBIT period.
- ws2812_chain owns the holding register, the shifter, the counters and the FSM.

Test Plan:
- Reset: rst=0 at an arbitrary time -> dout=0, in_ready=1, busy=0, no pulses; same after release.
- Full frame, NUM_LEDS=2, pixels 0xFF0000 then 0x00000F presented back-to-back:
  - 8 bits of 34 high / 26 low, then 36 bits of 17/43, then 4 bits of 34/26;
  - 2880 cycles of data, then 3840 low;
  - frame_done pulses once and busy falls on the next cycle.
- Underrun, NUM_LEDS=2, only 0xAAAAAA sent -> 24 alternating bits (1440 cycles), underrun pulses once, 3840 low cycles, no frame_done, then IDLE.
- Backpressure: in_valid held high with an incrementing counter as data:
  - in_ready never high while hold_full;
  - pixels appear on dout in order with none lost or duplicated;
  - latch gap between frames is exactly 3841 cycles.
- Reset mid-bit: rst low 10 cycles into a HIGH phase -> dout 0 the same instant; after release, IDLE with in_ready=1 and the old pixel not transmitted.
- BITS_PER_LED=32, NUM_LEDS=1, 0x80000001 -> bit 0 T1H, bits 1..30 T0H, bit 31 T1H; 1920 data cycles, then latch.
